frac_clken_gen: RTL and testbench
=================================

FRAC_CLKEN_GEN -- requirements
Module: frac_clken_gen

Interface
REQ-001 Parameter CHANNELS, default 3: number of independent clock-enable channels, 1..16.
REQ-002 Parameter ACC_W, default 32: phase-accumulator width per channel, 4..48.
REQ-003 Parameter LOCK_DELAY, default 16: settle cycles after reset/apply before locked asserts, 1..65535.
REQ-004 Derived CH_W = max(1, ceil(log2(CHANNELS))).
REQ-005 refclk  in  1  single clock; every register updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 cfg_wr  in  1  write strobe for the shadow config of channel cfg_ch.
REQ-008 cfg_ch  in  CH_W  target channel index.
REQ-009 cfg_inc  in  ACC_W  frequency word; f_ce = f_refclk * inc / 2^ACC_W.
REQ-010 cfg_phase  in  ACC_W  accumulator preload applied at apply; sets relative phase.
REQ-011 cfg_apply  in  1  one-cycle strobe: all channels load shadow config and realign together.
REQ-012 ce  out  CHANNELS  registered one-cycle enable pulses, bit i = channel i.
REQ-013 locked  out  1  high when all channels have run LOCK_DELAY cycles since the last reset/apply.

Function
REQ-014 Per channel: shadow regs inc_sh, ph_sh; active regs inc_act, acc (ACC_W each).
REQ-015 cfg_wr=1 with cfg_ch<CHANNELS: inc_sh/ph_sh[cfg_ch] take cfg_inc/cfg_phase at that edge; cfg_ch>=CHANNELS: write ignored, no state change.
REQ-016 Shadow writes without apply do not affect inc_act, acc, ce or locked.
REQ-017 cfg_apply=1 edge: every channel acc<=ph_sh, inc_act<=inc_sh; ce<=0 all bits; lock counter<=0; locked<=0.
REQ-018 cfg_wr and cfg_apply in same cycle: the write bypasses into the apply (channel loads cfg_inc/cfg_phase directly).
REQ-019 Normal edge (no rst, no apply): {c, acc} <= acc + inc_act (ACC_W+1-bit sum, acc wraps mod 2^ACC_W); ce[i] <= c.
REQ-020 Latency: ce[i] high in the cycle following the edge whose sum carried; pulse width exactly one refclk cycle per carry.
REQ-021 inc_act=0: channel never pulses; acc holds its value.
REQ-022 inc_act=2^ACC_W-1: ce high every cycle except at most the first after apply.
REQ-023 Over any 2^ACC_W consecutive cycles, pulse count on ce[i] equals inc_act exactly; no drift, no accumulated error.
REQ-024 Channels with equal inc_act keep the phase difference set by ph_sh indefinitely.
REQ-025 Lock counter: cleared by rst/apply, increments by 1 each other edge, saturates at LOCK_DELAY; locked<=1 on the edge the counter reaches LOCK_DELAY, i.e. high after the LOCK_DELAY-th edge following rst release or apply.
REQ-026 Shadow writes never deassert locked.

Reset
REQ-027 rst=1 edge: inc_sh, ph_sh, inc_act, acc, lock counter = 0; ce = 0; locked = 0.
REQ-028 rst has priority over cfg_apply and cfg_wr in the same cycle; both are discarded.
REQ-029 rst mid-operation: outputs return to reset values at the next edge; no partial pulse emitted.

Verification (CHANNELS=3, ACC_W=8, LOCK_DELAY=4)
REQ-030 rst 2 cycles then release, no config -> ce=3'b000 throughout; locked=0 for 3 edges, 1 after 4th edge.
REQ-031 wr ch0 inc=64 ph=0, then apply -> ce[0] first high after 4th edge post-apply, then every 4 cycles; locked drops on apply, returns after 4 edges.
REQ-032 wr ch0 inc=64 ph=0, ch1 inc=64 ph=128, apply -> ce[1] leads ce[0] by exactly 2 cycles, period 4, stable over 1000 cycles.
REQ-033 wr ch2 inc=96, apply -> exactly 3 pulses in every 8-cycle window aligned to apply; 96 pulses per 256 cycles.
REQ-034 wr ch=3 inc=1 (invalid) then apply -> no channel changes; wr ch1 inc=128 same cycle as apply -> ch1 pulses every 2 cycles from that apply.
REQ-035 rst asserted while ch0 runs with inc=64 -> ce=0, locked=0 next edge; after release no pulses until new config and apply.

Source files
------------

// File: rtl/frac_clken_gen.sv
// Fractional clock-enable generator: per-channel phase accumulators whose carries
// produce one-cycle enable pulses, with shadowed config and a common apply/realign.
module frac_clken_gen #(
  parameter int CHANNELS   = 3,
  parameter int ACC_W      = 32,
  parameter int LOCK_DELAY = 16,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]    cfg_inc,
  input  logic [ACC_W-1:0]    cfg_phase,
  input  logic                cfg_apply,
  output logic [CHANNELS-1:0] ce,
  output logic                locked
);

  localparam int LK_W = $clog2(LOCK_DELAY + 1);

  logic [ACC_W-1:0]    inc_sh_q  [CHANNELS];
  logic [ACC_W-1:0]    inc_sh_d  [CHANNELS];
  logic [ACC_W-1:0]    ph_sh_q   [CHANNELS];
  logic [ACC_W-1:0]    ph_sh_d   [CHANNELS];
  logic [ACC_W-1:0]    inc_act_q [CHANNELS];
  logic [ACC_W-1:0]    inc_act_d [CHANNELS];
  logic [ACC_W-1:0]    acc_q     [CHANNELS];
  logic [ACC_W-1:0]    acc_d     [CHANNELS];
  logic [ACC_W:0]      sum_c     [CHANNELS];
  logic [CHANNELS-1:0] ce_q, ce_d;
  logic [LK_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic                locked_q, locked_d;
  logic                wr_ok;

  function automatic logic [LK_W-1:0] lock_step(input logic [LK_W-1:0] cnt);
    if (cnt >= LK_W'(LOCK_DELAY)) return LK_W'(LOCK_DELAY);
    return cnt + LK_W'(1);
  endfunction

  always_comb begin
    inc_sh_d   = inc_sh_q;
    ph_sh_d    = ph_sh_q;
    inc_act_d  = inc_act_q;
    acc_d      = acc_q;
    ce_d       = '0;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    for (int i = 0; i < CHANNELS; i++) sum_c[i] = '0;

    wr_ok = cfg_wr && (int'(cfg_ch) < CHANNELS);
    if (wr_ok) begin
      inc_sh_d[cfg_ch] = cfg_inc;
      ph_sh_d[cfg_ch]  = cfg_phase;
    end

    // Apply reads the post-write shadow so a same-cycle write takes effect at once.
    if (cfg_apply) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_d[i]     = ph_sh_d[i];
        inc_act_d[i] = inc_sh_d[i];
      end
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sum_c[i] = {1'b0, acc_q[i]} + {1'b0, inc_act_q[i]};
        acc_d[i] = sum_c[i][ACC_W-1:0];
        ce_d[i]  = sum_c[i][ACC_W];
      end
      lock_cnt_d = lock_step(lock_cnt_q);
      locked_d   = (lock_cnt_d == LK_W'(LOCK_DELAY));
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        inc_sh_q[i]  <= '0;
        ph_sh_q[i]   <= '0;
        inc_act_q[i] <= '0;
        acc_q[i]     <= '0;
      end
      ce_q       <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      inc_sh_q   <= inc_sh_d;
      ph_sh_q    <= ph_sh_d;
      inc_act_q  <= inc_act_d;
      acc_q      <= acc_d;
      ce_q       <= ce_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign ce     = ce_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_frac_clken_gen.sv
// Bench for frac_clken_gen: closed-form pulse model compared every cycle, plus
// directed scenarios with hand-computed pulse positions and counts.
module tb_frac_clken_gen;
  localparam int CH = 3;
  localparam int W  = 8;
  localparam int LD = 4;

  logic          refclk;
  logic          rst;
  logic          cfg_wr;
  logic [1:0]    cfg_ch;
  logic [W-1:0]  cfg_inc;
  logic [W-1:0]  cfg_phase;
  logic          cfg_apply;
  logic [CH-1:0] ce;
  logic          locked;

  int passed = 0;
  int total  = 0;

  frac_clken_gen #(.CHANNELS(CH), .ACC_W(W), .LOCK_DELAY(LD)) dut (
    .refclk(refclk), .rst(rst), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .cfg_apply(cfg_apply),
    .ce(ce), .locked(locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  // Model: pulse after edge k since realign iff floor((ph + k*inc)/2^W) steps up.
  longint m_inc_sh [CH];
  longint m_ph_sh  [CH];
  longint m_inc    [CH];
  longint m_ph     [CH];
  longint m_k, m_lk;
  logic [CH-1:0] m_ce;
  logic          m_locked;
  bit            m_valid = 0;

  always @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_inc_sh[i] = 0; m_ph_sh[i] = 0; m_inc[i] = 0; m_ph[i] = 0;
      end
      m_k = 0; m_lk = 0; m_valid = 1;
    end else if (m_valid) begin
      if (cfg_wr && int'(cfg_ch) < CH) begin
        m_inc_sh[cfg_ch] = longint'(cfg_inc);
        m_ph_sh[cfg_ch]  = longint'(cfg_phase);
      end
      if (cfg_apply) begin
        for (int i = 0; i < CH; i++) begin
          m_inc[i] = m_inc_sh[i]; m_ph[i] = m_ph_sh[i];
        end
        m_k = 0; m_lk = 0;
      end else begin
        m_k++;
        if (m_lk < LD) m_lk++;
      end
    end
    for (int i = 0; i < CH; i++)
      m_ce[i] = (m_k > 0) &&
                (((m_ph[i] + m_k * m_inc[i]) >> W) != ((m_ph[i] + (m_k - 1) * m_inc[i]) >> W));
    m_locked = (m_lk >= LD);
  end

  always @(negedge refclk) begin
    if (m_valid) begin
      chk("ce_model", 64'(ce), 64'(m_ce));
      chk("locked_model", 64'(locked), 64'(m_locked));
    end
  end

  task automatic tick();
    @(negedge refclk);
  endtask

  task automatic wr(input int ch, input int inc, input int ph);
    cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_inc = W'(inc); cfg_phase = W'(ph);
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic apply();
    cfg_apply = 1'b1;
    tick();
    cfg_apply = 1'b0;
  endtask

  // ch < 0 counts cycles where any channel pulses.
  task automatic count_pulses(input int ch, input int n, output int cnt);
    cnt = 0;
    for (int t = 0; t < n; t++) begin
      tick();
      if (ch < 0) cnt += int'(|ce);
      else        cnt += int'(ce[ch]);
    end
  endtask

  int f0, f1, c, c2, bad, sum;
  logic h0 [1000];
  logic h1 [1000];

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_phase = '0; cfg_apply = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_ce", 64'(ce), 64'd0);
    chk("reset_locked", 64'(locked), 64'd0);
    tick(); tick(); tick();
    chk("locked_after_3", 64'(locked), 64'd0);
    tick();
    chk("locked_after_4", 64'(locked), 64'd1);
    chk("idle_ce", 64'(ce), 64'd0);

    // Single channel, period 4
    wr(0, 64, 0);
    chk("shadow_wr_keeps_locked", 64'(locked), 64'd1);
    apply();
    chk("apply_drops_locked", 64'(locked), 64'd0);
    chk("apply_clears_ce", 64'(ce), 64'd0);
    f0 = 0;
    for (int t = 1; t <= 8 && f0 == 0; t++) begin
      tick();
      if (ce[0]) f0 = t;
    end
    chk("ch0_first_pulse", 64'(f0), 64'd4);
    chk("locked_at_first_pulse", 64'(locked), 64'd1);
    count_pulses(0, 16, c);
    chk("ch0_16cyc_count", 64'(c), 64'd4);

    // Two channels, half-period phase offset
    wr(0, 64, 0);
    wr(1, 64, 128);
    apply();
    f0 = 0; f1 = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (ce[0] && f0 == 0) f0 = t;
      if (ce[1] && f1 == 0) f1 = t;
    end
    chk("ch1_first_pulse", 64'(f1), 64'd2);
    chk("ch0_first_pulse_b", 64'(f0), 64'd4);
    c = 0; c2 = 0;
    for (int t = 0; t < 1000; t++) begin
      tick();
      h0[t] = ce[0]; h1[t] = ce[1];
      c += int'(ce[0]); c2 += int'(ce[1]);
    end
    bad = 0;
    for (int t = 0; t < 998; t++) if (h1[t] != h0[t+2]) bad++;
    chk("ch1_leads_by_2", 64'(bad), 64'd0);
    chk("ch0_1000_count", 64'(c), 64'd250);
    chk("ch1_1000_count", 64'(c2), 64'd250);

    // 3 pulses per 8 cycles
    wr(2, 96, 0);
    apply();
    bad = 0; sum = 0;
    for (int w = 0; w < 32; w++) begin
      count_pulses(2, 8, c);
      if (c != 3) bad++;
      sum += c;
    end
    chk("ch2_windows_of_3", 64'(bad), 64'd0);
    chk("ch2_256_count", 64'(sum), 64'd96);

    // Invalid channel write is ignored
    wr(3, 1, 0);
    apply();
    count_pulses(2, 8, c);
    chk("invalid_wr_ch2", 64'(c), 64'd3);
    count_pulses(0, 8, c);
    chk("invalid_wr_ch0", 64'(c), 64'd2);

    // Write in the same cycle as apply bypasses into the active config
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_inc = 8'd128; cfg_phase = 8'd0; cfg_apply = 1'b1;
    tick();
    cfg_wr = 1'b0; cfg_apply = 1'b0;
    f1 = 0; c = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (ce[1] && f1 == 0) f1 = t;
      c += int'(ce[1]);
    end
    chk("bypass_first_pulse", 64'(f1), 64'd2);
    chk("bypass_8cyc_count", 64'(c), 64'd4);

    // Mid-run reset wins over simultaneous write and apply
    count_pulses(0, 3, c);
    rst = 1'b1; cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_inc = 8'd64; cfg_apply = 1'b1;
    tick();
    rst = 1'b0; cfg_wr = 1'b0; cfg_apply = 1'b0;
    chk("midrst_ce", 64'(ce), 64'd0);
    chk("midrst_locked", 64'(locked), 64'd0);
    count_pulses(-1, 300, c);
    chk("post_rst_no_pulses", 64'(c), 64'd0);
    apply();
    count_pulses(-1, 50, c);
    chk("rst_discards_wr", 64'(c), 64'd0);

    // Maximum increment pulses every cycle after the first
    wr(0, 255, 0);
    apply();
    count_pulses(0, 20, c);
    chk("inc_max_count", 64'(c), 64'd19);

    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
